multicycle_control: RTL and testbench

Multi-cycle RV32I control FSM that supersedes the single-cycle main decoder. It sequences fetch, decode, execute, memory and writeback over several clocks and adds jump/upper-immediate support, memory wait-state handshaking with timeout, and an illegal-opcode trap. It sits between the instruction register and the shared-memory multi-cycle datapath; ALU funct decode stays in the existing ALU control block.

---
 rtl/riscv_ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_opcode_decode.sv | 32 +++
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: opcodes, FSM states,
// and the mux/ALU select encodings the datapath expects.
package riscv_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // Encodings are visible on the debug state port, so keep them fixed
    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWr   = 4'd6,
        StMemWb   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10,
        StJalr    = 4'd11,
        StLui     = 4'd12,
        StTrap    = 4'd13
    } state_e;

    // alu_op
    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpR      = 2'b10;
    localparam logic [1:0] AluOpI      = 2'b11;

    // alu_src_a
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcARs1   = 2'b01;
    localparam logic [1:0] SrcAZero  = 2'b10;
    localparam logic [1:0] SrcAOldPc = 2'b11;

    // alu_src_b
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    // pc_src
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;

    // mem_to_reg
    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Maps the instruction opcode to the state that follows DECODE.
// Unknown opcodes (and jump/upper-immediate ones when disabled) steer to TRAP.
module ctrl_opcode_decode
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_JUMP = 1'b1
) (
    input  logic [6:0] opcode,
    output state_e     next_state,
    output logic       illegal
);

    // Opcode lookup; everything unmatched falls through to TRAP
    always_comb begin
        next_state = StTrap;
        case (opcode)
            OpRType:  next_state = StExecR;
            OpIType:  next_state = StExecI;
            OpLoad:   next_state = StMemAddr;
            OpStore:  next_state = StMemAddr;
            OpBranch: next_state = StBranch;
            OpJal:    next_state = ENABLE_JUMP ? StJal : StTrap;
            OpJalr:   next_state = ENABLE_JUMP ? StJalr : StTrap;
            OpLui:    next_state = ENABLE_JUMP ? StLui : StTrap;
            // AUIPC: DECODE already formed oldPC + imm in ALUOut
            OpAuipc:  next_state = ENABLE_JUMP ? StAluWb : StTrap;
            default:  next_state = StTrap;
        endcase
        illegal = (next_state == StTrap);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// guards memory waits with a timeout and traps on illegal opcodes.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter bit          ENABLE_JUMP = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       trap_clr,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       trap,
    output logic       trap_cause,
    output logic       retire,
    output logic [3:0] state
);

    // A disabled timeout still needs a legal (1-bit) counter
    localparam int unsigned CntW  = (TO_W > 0) ? TO_W : 1;
    localparam int unsigned Limit = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] LimitCnt = CntW'(Limit);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cause_q, cause_d;
    logic            new_cause;
    logic            timeout_hit;
    state_e          dec_next;
    logic            dec_illegal;

    ctrl_opcode_decode #(
        .ENABLE_JUMP(ENABLE_JUMP)
    ) u_decode (
        .opcode    (opcode),
        .next_state(dec_next),
        .illegal   (dec_illegal)
    );

    // mem_ready in the same cycle takes priority over the timeout
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == LimitCnt) && !mem_ready;

    // Next-state and control output decode
    always_comb begin
        state_d       = state_q;
        new_cause     = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PcSrcAlu;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        alu_op        = AluOpAdd;
        reg_write     = 1'b0;
        mem_to_reg    = WbAluOut;
        trap          = 1'b0;
        retire        = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    new_cause = 1'b1;
                end
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                state_d   = dec_next;
                new_cause = 1'b0;
            end
            StExecR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluOpR;
                state_d   = StAluWb;
            end
            StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluOpI;
                state_d   = StAluWb;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                state_d   = StAluWb;
            end
            StMemAddr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    new_cause = 1'b1;
                end
            end
            StMemWr: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d   = StTrap;
                    new_cause = 1'b1;
                end
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = WbMdr;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                mem_to_reg = WbAluOut;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a     = SrcARs1;
                alu_src_b     = SrcBRs2;
                alu_op        = AluOpBranch;
                pc_write_cond = 1'b1;
                pc_src        = PcSrcAluOut;
                retire        = 1'b1;
                state_d       = StFetch;
            end
            StJal: begin
                pc_write   = 1'b1;
                pc_src     = PcSrcAluOut;
                reg_write  = 1'b1;
                mem_to_reg = WbPc;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                pc_write   = 1'b1;
                pc_src     = PcSrcAlu;
                reg_write  = 1'b1;
                mem_to_reg = WbPc;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                trap = 1'b1;
                if (trap_clr) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Wait counter and trap cause bookkeeping
    always_comb begin
        cnt_d   = cnt_q;
        cause_d = cause_q;
        // Any state change clears the counter, which covers entry to every memory state
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_req && !mem_ready && (MEM_TIMEOUT != 0)) begin
            cnt_d = cnt_q + CntW'(1);
        end
        if (state_q != StTrap && state_d == StTrap) begin
            cause_d = new_cause;
        end else if (state_q == StTrap && trap_clr) begin
            cause_d = 1'b0;
        end
    end

    // State, counter and cause registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; a second instance covers ENABLE_JUMP=0.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       trap_clr;

    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, mem_to_reg;
    logic       reg_write, trap, trap_cause, retire;
    logic [3:0] state;

    logic       nj_mem_req, nj_mem_we, nj_iord, nj_ir_write, nj_pc_write, nj_pc_write_cond;
    logic [1:0] nj_pc_src, nj_alu_src_a, nj_alu_src_b, nj_alu_op, nj_mem_to_reg;
    logic       nj_reg_write, nj_trap, nj_trap_cause, nj_retire;
    logic [3:0] nj_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .ENABLE_JUMP(1'b1),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .trap_clr(trap_clr), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .trap(trap),
        .trap_cause(trap_cause), .retire(retire), .state(state)
    );

    multicycle_control #(
        .ENABLE_JUMP(1'b0),
        .MEM_TIMEOUT(15)
    ) dut_nj (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .trap_clr(trap_clr), .mem_req(nj_mem_req), .mem_we(nj_mem_we), .iord(nj_iord),
        .ir_write(nj_ir_write), .pc_write(nj_pc_write), .pc_write_cond(nj_pc_write_cond),
        .pc_src(nj_pc_src), .alu_src_a(nj_alu_src_a), .alu_src_b(nj_alu_src_b),
        .alu_op(nj_alu_op), .reg_write(nj_reg_write), .mem_to_reg(nj_mem_to_reg),
        .trap(nj_trap), .trap_cause(nj_trap_cause), .retire(nj_retire), .state(nj_state)
    );

    // Pulse reset; returns just after a falling edge with reset released
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0; trap_clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; trap_clr = 1'b0; opcode = 7'b0;
        #2;
        checks++;
        if ({state, trap, trap_cause, retire, reg_write, pc_write, ir_write} !== 10'b0000_000000) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b",
                     {state, trap, trap_cause, retire, reg_write, pc_write, ir_write}, 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, mem_req, iord, alu_src_b} !== {4'd0, 1'b1, 1'b0, 2'b01}) begin
            errors++;
            $display("FAIL reset_fetch got=%b want=%b", {state, mem_req, iord, alu_src_b},
                     {4'd0, 1'b1, 1'b0, 2'b01});
        end
    endtask

    task automatic test_add();
        int nret = 0;
        do_reset();
        opcode = 7'b0110011; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state, ir_write, pc_write, mem_req, reg_write} !== {4'd0, 4'b1110}) begin
            errors++;
            $display("FAIL add_c1 got=%b want=%b", {state, ir_write, pc_write, mem_req, reg_write},
                     {4'd0, 4'b1110});
        end
        nret += int'(retire);
        @(negedge clk); #1;
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op, reg_write} !== {4'd1, 2'b11, 2'b10, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL add_c2 got=%b want=%b", {state, alu_src_a, alu_src_b, alu_op, reg_write},
                     {4'd1, 2'b11, 2'b10, 2'b00, 1'b0});
        end
        nret += int'(retire);
        @(negedge clk); #1;
        checks++;
        if ({state, alu_src_a, alu_src_b, alu_op, reg_write} !== {4'd2, 2'b01, 2'b00, 2'b10, 1'b0}) begin
            errors++;
            $display("FAIL add_c3 got=%b want=%b", {state, alu_src_a, alu_src_b, alu_op, reg_write},
                     {4'd2, 2'b01, 2'b00, 2'b10, 1'b0});
        end
        nret += int'(retire);
        @(negedge clk); #1;
        checks++;
        if ({state, reg_write, mem_to_reg, retire} !== {4'd8, 1'b1, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL add_c4 got=%b want=%b", {state, reg_write, mem_to_reg, retire},
                     {4'd8, 1'b1, 2'b00, 1'b1});
        end
        nret += int'(retire);
        @(negedge clk); #1;
        checks++;
        if ({state, reg_write} !== {4'd0, 1'b0} || nret != 1) begin
            errors++;
            $display("FAIL add_c5 got state=%0d reg_write=%b retires=%0d want state=0 reg_write=0 retires=1",
                     state, reg_write, nret);
        end
    endtask

    task automatic test_load_wait();
        int lat = 0;
        int reqs = 0;
        logic done = 1'b0;
        do_reset();
        opcode = 7'b0000011;
        // i: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3-5 MEM_RD waiting, 6 MEM_RD ready, 7 MEM_WB
        for (int i = 0; i < 20 && !done; i++) begin
            mem_ready = (i == 0) || (i >= 6);
            #1;
            lat++;
            if (state == 4'd5 && mem_req) reqs++;
            if (retire) begin
                done = 1'b1;
                checks++;
                if ({state, reg_write, mem_to_reg} !== {4'd7, 1'b1, 2'b01}) begin
                    errors++;
                    $display("FAIL lw_wb got=%b want=%b", {state, reg_write, mem_to_reg},
                             {4'd7, 1'b1, 2'b01});
                end
            end
            @(negedge clk);
        end
        checks++;
        if (lat != 8 || reqs != 4) begin
            errors++;
            $display("FAIL lw_latency got lat=%0d reqs=%0d want lat=8 reqs=4", lat, reqs);
        end
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL lw_return got=%0d want=0", state);
        end
    endtask

    task automatic test_store_timeout();
        int reqs = 0;
        logic done = 1'b0;
        do_reset();
        opcode = 7'b0100011;
        for (int i = 0; i < 60 && !done; i++) begin
            mem_ready = (i == 0);
            #1;
            if (state == 4'd6 && mem_req && mem_we && iord) reqs++;
            if (state == 4'd13) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (reqs != 15 || {state, trap, trap_cause, mem_req, retire} !== {4'd13, 4'b1100}) begin
            errors++;
            $display("FAIL sw_timeout got reqs=%0d st=%0d trap=%b cause=%b req=%b want reqs=15 st=13 1 1 0",
                     reqs, state, trap, trap_cause, mem_req);
        end
        @(negedge clk); #1;
        checks++;
        if ({state, trap_cause} !== {4'd13, 1'b1}) begin
            errors++;
            $display("FAIL trap_hold got=%b want=%b", {state, trap_cause}, {4'd13, 1'b1});
        end
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        #1;
        checks++;
        if ({state, trap, trap_cause, mem_req} !== {4'd0, 3'b001}) begin
            errors++;
            $display("FAIL trap_clr got=%b want=%b", {state, trap, trap_cause, mem_req}, {4'd0, 3'b001});
        end
        // trap_clr outside TRAP has no effect
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        #1;
        checks++;
        if ({state, trap, trap_cause} !== {4'd0, 2'b00}) begin
            errors++;
            $display("FAIL clr_ignored got=%b want=%b", {state, trap, trap_cause}, {4'd0, 2'b00});
        end
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 7'b0000000; mem_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL ill_decode got=%0d want=1", state);
        end
        @(negedge clk); #1;
        checks++;
        if ({state, trap, trap_cause, mem_req, retire} !== {4'd13, 4'b1000}) begin
            errors++;
            $display("FAIL ill_trap got=%b want=%b", {state, trap, trap_cause, mem_req, retire},
                     {4'd13, 4'b1000});
        end
    endtask

    task automatic test_nojump();
        do_reset();
        opcode = 7'b1101111; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({nj_state, nj_trap, nj_trap_cause, nj_pc_write, nj_reg_write} !== {4'd13, 4'b1000}) begin
            errors++;
            $display("FAIL nojump_trap got=%b want=%b",
                     {nj_state, nj_trap, nj_trap_cause, nj_pc_write, nj_reg_write}, {4'd13, 4'b1000});
        end
    endtask

    task automatic test_jal();
        do_reset();
        opcode = 7'b1101111; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({state, pc_write, pc_src, mem_to_reg, reg_write, retire} !==
            {4'd10, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL jal_c3 got=%b want=%b", {state, pc_write, pc_src, mem_to_reg, reg_write, retire},
                     {4'd10, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1});
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jal_return got=%0d want=0", state);
        end
    endtask

    task automatic test_beq();
        do_reset();
        opcode = 7'b1100011; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({state, pc_write_cond, alu_op, pc_src, pc_write, reg_write, retire} !==
            {4'd9, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL beq_c3 got=%b want=%b",
                     {state, pc_write_cond, alu_op, pc_src, pc_write, reg_write, retire},
                     {4'd9, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_auipc();
        do_reset();
        opcode = 7'b0010111; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({state, reg_write, retire} !== {4'd8, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL auipc_c3 got=%b want=%b", {state, reg_write, retire}, {4'd8, 1'b1, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        opcode = 7'b0000011; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if ({state, mem_req} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL mid_wait got=%b want=%b", {state, mem_req}, {4'd5, 1'b1});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state, retire, reg_write, ir_write, pc_write, iord, mem_we, trap, trap_cause} !==
            {4'd0, 8'b0}) begin
            errors++;
            $display("FAIL mid_reset got=%b want=%b",
                     {state, retire, reg_write, ir_write, pc_write, iord, mem_we, trap, trap_cause},
                     {4'd0, 8'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state, mem_req, retire} !== {4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_release got=%b want=%b", {state, mem_req, retire}, {4'd0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_wait();
        test_store_timeout();
        test_illegal();
        test_nojump();
        test_jal();
        test_beq();
        test_auipc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
